// File: rtl/accl_pair_sequencer.sv
// accl_pair_sequencer: streams (i,j) body pairs into the fixed-latency getAccl pipeline and buffers results in a credit-guarded FIFO.
// Define SKIP_SELF_EN to suppress reading and issuing the j==i self pair.
module accl_pair_sequencer #(
  parameter int IDX_W      = 4,
  parameter int PIPE_LAT   = 123,
  parameter int FIFO_DEPTH = 128,
  parameter int FIFO_AW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [63:0]      rd_x,
  input  logic [63:0]      rd_y,
  input  logic [63:0]      rd_m,
  output logic [63:0]      x1,
  output logic [63:0]      y1,
  output logic [63:0]      x2,
  output logic [63:0]      y2,
  output logic [63:0]      m2,
  input  logic [63:0]      ax_in,
  input  logic [63:0]      ay_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_i,
  output logic [63:0]      res_ax,
  output logic [63:0]      res_ay,
  output logic             res_last
);
  localparam int TW = IDX_W + 2;
  localparam int EW = IDX_W + 129;
  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] CRED_MAX = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD_I, LATCH_I, STREAM, NEXT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IDX_W:0] n_q, n_d, i_q, i_d, j_q, j_d, last_j;
  logic busy_q, busy_d, done_q, done_d, self_j, rsv, wr, rd;
  logic [63:0] hx_q, hx_d, hy_q, hy_d;
  logic [63:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, m2_q, m2_d;
  logic [TW-1:0] pa_q, pa_d, tb_q, ex;
  logic [PIPE_LAT-1:0][TW-1:0] sr_q, sr_d;
  logic [FIFO_AW:0] cnt_q, cnt_d, fc_q, fc_d;
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
`ifdef SKIP_SELF_EN
  assign self_j = j_q == i_q;
  assign last_j = (i_q == n_q - ONE) ? n_q - ONE - ONE : n_q - ONE;
`else
  assign self_j = 1'b0;
  assign last_j = n_q - ONE;
`endif
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    busy_d = busy_q;
    done_d = 1'b0;
    hx_d = hx_q;
    hy_d = hy_q;
    pa_d = '0;
    rsv = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        n_d = n_bodies;
        i_d = '0;
        busy_d = 1'b1;
        state_d = (n_bodies == '0) ? DRAIN : LOAD_I;
      end
      LOAD_I: state_d = LATCH_I;
      LATCH_I: begin
        hx_d = rd_x;
        hy_d = rd_y;
        j_d = '0;
        state_d = STREAM;
      end
      STREAM: if (self_j) begin
        j_d = j_q + ONE;
        state_d = (j_q == n_q - ONE) ? NEXT : STREAM;
      end else if (cnt_q != CRED_MAX) begin
        rsv = 1'b1;
        pa_d = {1'b1, i_q[IDX_W-1:0], j_q == last_j};
        j_d = j_q + ONE;
        state_d = (j_q == last_j) ? NEXT : STREAM;
      end
      NEXT: begin
        i_d = i_q + ONE;
        state_d = (i_q + ONE == n_q) ? DRAIN : LOAD_I;
      end
      DRAIN: if (cnt_q == '0) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Credits cover every pair from read reservation until its result is popped.
  always_comb begin
    {x1_d, y1_d, x2_d, y2_d, m2_d} = pa_q[TW-1] ? {hx_q, hy_q, rd_x, rd_y, rd_m} : {x1_q, y1_q, x2_q, y2_q, m2_q};
    sr_d = {sr_q[PIPE_LAT-2:0], tb_q};
    cnt_d = cnt_q + {{FIFO_AW{1'b0}}, rsv} - {{FIFO_AW{1'b0}}, rd};
    fc_d = fc_q + {{FIFO_AW{1'b0}}, wr} - {{FIFO_AW{1'b0}}, rd};
    wp_d = wp_q + {{(FIFO_AW-1){1'b0}}, wr};
    rp_d = rp_q + {{(FIFO_AW-1){1'b0}}, rd};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      i_q <= '0;
      j_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hx_q <= '0;
      hy_q <= '0;
      {x1_q, y1_q, x2_q, y2_q, m2_q} <= '0;
      pa_q <= '0;
      tb_q <= '0;
      sr_q <= '0;
      cnt_q <= '0;
      fc_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      {x1_q, y1_q, x2_q, y2_q, m2_q} <= {x1_d, y1_d, x2_d, y2_d, m2_d};
      pa_q <= pa_d;
      tb_q <= pa_q;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= {ex[TW-2:1], ex[0], ax_in, ay_in};
  assign ex = sr_q[PIPE_LAT-1];
  assign wr = ex[TW-1];
  assign res_valid = fc_q != '0;
  assign rd = res_valid & res_ready;
  assign {res_i, res_last, res_ax, res_ay} = res_valid ? mem_q[rp_q] : '0;
  assign rd_idx = (state_q == LOAD_I) ? i_q[IDX_W-1:0] : j_q[IDX_W-1:0];
  assign busy = busy_q;
  assign done = done_q;
  assign {x1, y1, x2, y2, m2} = {x1_q, y1_q, x2_q, y2_q, m2_q};
endmodule

// File: doc/accl_pair_sequencer.md
Name: accl_pair_sequencer

Overview:
- Feeds body pairs (i, j) into the fixed-latency, non-stallable getAccl pipeline and collects its ax/ay outputs.
- Tracks in-flight pairs with a tag shift register and buffers results in an output FIFO.
- Uses credit-based issue so the FIFO never overflows under downstream backpressure.
- Sits between the body-state RAM and the downstream per-body force accumulator.

Parameters:
IDX_W, 4, body index width; up to 2^IDX_W bodies
PIPE_LAT, 123, cycles from x1..m2 driven to matching ax_in/ay_in valid (getAccl latency)
FIFO_DEPTH, 128, result FIFO entries; power of two; must be >= 2
FIFO_AW, 7, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
n_bodies  in  IDX_W+1  body count, latched at start
busy  out  1  high from start-accept until done
done  out  1  one-cycle pulse at pass completion
rd_idx  out  IDX_W  body RAM read address; synchronous RAM, 1-cycle read latency
rd_x, rd_y, rd_m  in  64 each  body RAM data; mass already multiplied by G
x1, y1, x2, y2, m2  out  64 each  getAccl operands
ax_in, ay_in  in  64 each  getAccl results
res_valid  out  1  result available
res_ready  in  1  downstream accepts
res_i  out  IDX_W  body the acceleration applies to
res_ax, res_ay  out  64 each  acceleration components
res_last  out  1  final pair for res_i

Behaviour:
- Reset: all outputs 0; FSM IDLE; tag shift register cleared; FIFO empty; credit count 0. Reset mid-pass abandons the pass: no done pulse, all in-flight tags discarded.
- FSM states: IDLE, LOAD_I, LATCH_I, STREAM, NEXT, DRAIN.
- IDLE:
  - start=1 latches n_bodies, sets i=0, asserts busy.
  - Goes to DRAIN if n_bodies==0, else to LOAD_I.
  - start while busy is ignored.
- LOAD_I: rd_idx=i. Next state LATCH_I.
- LATCH_I: capture rd_x/rd_y into x1/y1 holding registers; j=0. Next state STREAM.
- STREAM:
  - Each cycle with credit available (in-flight + FIFO occupancy + pending read < FIFO_DEPTH): rd_idx=j, reserve one credit, j++.
  - The cycle after each read: drive x2=rd_x, y2=rd_y, m2=rd_m, x1/y1 from holding registers, and push tag {valid=1, i, last=(j==n_bodies-1)} into the PIPE_LAT-deep tag shift register.
  - Stall cycles push valid=0 tags; operands hold their previous values.
  - After the read of j=n_bodies-1, go to NEXT.
- NEXT: i++. If i==n_bodies go to DRAIN, else LOAD_I.
- DRAIN: wait until no valid tags are in flight and the FIFO is empty, then pulse done, deassert busy, go to IDLE.
- Self pair j==i is issued normally; getAccl zeroes its mass, so a result of 0 is expected.
- Tag capture: when a valid tag exits the shift register, write {tag.i, tag.last, ax_in, ay_in} to the FIFO in the same cycle. Result order equals issue order.
- Output: res_* is the FIFO head. An entry pops on res_valid && res_ready. A simultaneous FIFO write and pop both occur. Credit is released on pop.
- FIFO full is unreachable by construction; an overflow write is a design error and must be flagged by a bench assertion.
- Latency:
  - Start-accept edge to first getAccl issue: 4 cycles.
  - First res_valid: 5+PIPE_LAT cycles after start-accept, with credit free.
  - Throughput: 1 pair/cycle within STREAM, plus 3 overhead cycles per i.

Optional Feature:
SKIP_SELF_EN:
- Defined: pairs with j==i are not read or issued. res_last marks the last issued j for that i (j=n_bodies-2 when i==n_bodies-1). With n_bodies==1, no results are produced and done pulses after DRAIN.
- Undefined: self pairs are issued as described in Behaviour.

Test Plan:
- Result ordering: n_bodies=3, res_ready=1, stub pipeline returning (i*16+j, -(i*16+j)). Require 9 results in order (0,0),(0,1),...,(2,2); res_last on results 3, 6 and 9; first res_valid at 128 cycles after start-accept; done after last pop.
- Backpressure: n_bodies=16, res_ready=0. Require exactly 128 RAM reads, then rd_idx frozen and no FIFO overflow. Release res_ready: all 256 results delivered in order, single done pulse.
- Random readiness: res_ready random 30% high, n_bodies=5. Require 25 results, no drops or duplicates, tags match the stub's encoded values.
- Reset mid-pass: assert rst_n=0 during STREAM of i=2, n_bodies=4. Require all outputs 0, res_valid=0 for PIPE_LAT+10 cycles, no done pulse. A new start then completes cleanly with 16 results.
- Start handling: n_bodies=0 start gives a done pulse within 3 cycles with 0 results; a start pulse while busy changes nothing.
- SKIP_SELF_EN: n_bodies=3 gives 6 results, none with j==i, res_last on (0,2), (1,2) and (2,1); n_bodies=1 gives done with 0 results.
